// File: rtl/ps2_kbd_fifo_if.sv
// Scan-code pop interface between the PS/2 keyboard receiver and its consumer.
interface ps2_kbd_fifo_if;
  logic       rd_en;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_break;
  logic       code_ext;

  modport master (output code_valid, code_data, code_break, code_ext, input rd_en);
  modport slave  (input code_valid, code_data, code_break, code_ext, output rd_en);
endinterface

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: oversampled framing, parity/stop check, E0/F0 prefix
// folding and a first-word-fall-through scan-code FIFO.
module ps2_kbd_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 clr_err,
  ps2_kbd_fifo_if.master       kbd,
  output logic                 overflow,
  output logic                 parity_err,
  output logic [CNT_WIDTH-1:0] press_cnt
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PTR_W   = ADDR_WIDTH + 1;
  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   clk_sync, data_sync;
  logic                     clk_prev;
  logic                     clk_s, data_s, fe;
  logic [TO_W-1:0]          to_cnt;
  logic                     timeout;
  logic [2:0]               bitcnt;
  logic [7:0]               shreg;
  logic                     par_bit;
  logic                     start_c, shift_c, par_c, stop_c;
  logic                     frame_ok, frame_bad, is_e0, is_f0, push;
  logic                     ext_pend, brk_pend;
  logic [ENTRY_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic                     full, pop, wr_ok, drop;

  // Synchronisers and falling-edge detect on the PS/2 clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fe     = clk_prev & ~clk_s;

  // Watchdog against a keyboard that stops clocking mid-frame
  assign timeout = (state_q != S_IDLE) && !fe && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           to_cnt <= '0;
    else if (state_q == S_IDLE || fe)   to_cnt <= '0;
    else if (!timeout)                  to_cnt <= to_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fe) begin
      case (state_q)
        S_IDLE:   if (!data_s) state_d = S_DATA;
        S_DATA:   if (bitcnt == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    start_c = 1'b0;
    shift_c = 1'b0;
    par_c   = 1'b0;
    stop_c  = 1'b0;
    if (fe) begin
      case (state_q)
        S_IDLE:   start_c = !data_s;
        S_DATA:   shift_c = 1'b1;
        S_PARITY: par_c   = 1'b1;
        S_STOP:   stop_c  = 1'b1;
        default:  ;
      endcase
    end
  end

  // Frame shift register, LSB arrives first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (start_c) bitcnt <= '0;
      if (shift_c) begin
        shreg  <= {data_s, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (par_c) par_bit <= data_s;
    end
  end

  assign frame_ok  = stop_c && data_s && (^{shreg, par_bit});
  assign frame_bad = stop_c && !frame_ok;
  assign is_e0     = (shreg == 8'hE0);
  assign is_f0     = (shreg == 8'hF0);
  assign push      = frame_ok && !is_e0 && !is_f0;

  assign full     = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign pop      = kbd.rd_en && kbd.code_valid;
  assign wr_ok    = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign wr_ptr_d = wr_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign rd_ptr_d = pop   ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[ADDR_WIDTH'(i)] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      kbd.code_valid <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {ext_pend, brk_pend, shreg};
      wr_ptr         <= wr_ptr_d;
      rd_ptr         <= rd_ptr_d;
      kbd.code_valid <= (wr_ptr_d != rd_ptr_d);
    end
  end

  assign {kbd.code_ext, kbd.code_break, kbd.code_data} = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Prefix flags, make counter and sticky errors (a new error beats clr_err)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      press_cnt  <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (frame_ok) begin
        if (is_e0)      ext_pend <= 1'b1;
        else if (is_f0) brk_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
      if (wr_ok && !brk_pend) press_cnt <= press_cnt + CNT_WIDTH'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (frame_bad)    parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
    end
  end

endmodule
